assert_report_arbiter: RTL and testbench

// Collects per-cycle violation pulses from up to N_SRC assertion monitors.

---
 rtl/assert_report_arbiter.sv | 167 ++++++++++++++++
 tb/tb_assert_report_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/assert_report_arbiter.sv
// ---------------------------------------------------------------------------
// assert_report_arbiter
//
// Gathers single-cycle violation pulses from up to N_SRC assertion monitors.
// It queues one pending report per source and serializes the reports
// round-robin onto a single valid/ready channel for the trace printer.
// A repeat violation from a source that is already queued is merged into
// that source's report and flagged through rpt_dropped.
// The block also keeps a saturating count of accepted violations and raises
// a sticky halt request once the count reaches HALT_THRESH.
//
// Ports
//   clock       in   1      single clock, all state updates on posedge
//   reset_n     in   1      asynchronous active-low reset
//   enable      in   1      1: fail_i sampled, 0: fail_i ignored
//   clear       in   1      synchronous clear of pending/overflow/count/halt
//   fail_i      in   N_SRC  bit k high = monitor k saw a violation this cycle
//   rpt_valid   out  1      report available
//   rpt_ready   in   1      consumer accepts when rpt_valid & rpt_ready
//   rpt_id      out  ID_W   index of the reporting source
//   rpt_dropped out  1      further violations of rpt_id were merged
//   fail_count  out  CNT_W  saturating total of accepted violation events
//   halt_req    out  1      sticky, fail_count reached HALT_THRESH
// ---------------------------------------------------------------------------
module assert_report_arbiter #(
  parameter int N_SRC       = 8,
  parameter int ID_W        = 3,
  parameter int CNT_W       = 16,
  parameter int HALT_THRESH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [N_SRC-1:0] fail_i,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [ID_W-1:0]  rpt_id,
  output logic             rpt_dropped,
  output logic [CNT_W-1:0] fail_count,
  output logic             halt_req
);

  localparam int POP_W = $clog2(N_SRC + 1);
  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HALT_VAL = CNT_W'(HALT_THRESH);

  typedef enum logic {IDLE, REPORT} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] overflow_q, overflow_d;
  logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
  logic [ID_W-1:0]  rptId_q, rptId_d;
  logic             rptDropped_q, rptDropped_d;
  logic [CNT_W-1:0] failCount_q, failCount_d;
  logic             haltReq_q, haltReq_d;

  logic [N_SRC-1:0] acc;
  logic [POP_W-1:0] accPop;
  logic [ID_W-1:0]  winner;
  logic             winnerFound;
  logic             fire;
  logic             grant;

  assign acc  = fail_i & {N_SRC{enable}};
  assign fire = (state_q == REPORT) && rpt_ready;

  // Round-robin search starting just after the last granted source.
  always_comb begin
    int idx;
    winner      = '0;
    winnerFound = 1'b0;
    idx         = 0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = (int'(rrPtr_q) + i) % N_SRC;
      if (!winnerFound && pending_q[idx]) begin
        winnerFound = 1'b1;
        winner      = ID_W'(idx);
      end
    end
  end

  always_comb begin
    accPop = '0;
    for (int k = 0; k < N_SRC; k++) begin
      accPop = accPop + POP_W'(acc[k]);
    end
  end

  // A grant happens from IDLE, or back-to-back on a handshake. Clear empties
  // the queue, so nothing is granted on the clear edge.
  assign grant = !clear && winnerFound && ((state_q == IDLE) || fire);

  // Next-state, queue and counter logic.
  always_comb begin
    logic [N_SRC-1:0] grantMask;
    logic [N_SRC-1:0] pendBase;
    logic [N_SRC-1:0] ovBase;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cntBase;

    state_d      = state_q;
    rrPtr_d      = rrPtr_q;
    rptId_d      = rptId_q;
    rptDropped_d = rptDropped_q;
    grantMask    = '0;

    if (grant) begin
      grantMask[winner] = 1'b1;
      rrPtr_d           = winner;
      rptId_d           = winner;
      rptDropped_d      = overflow_q[winner];
    end

    unique case (state_q)
      IDLE:    if (grant) state_d = REPORT;
      REPORT:  if (fire && !grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A granted bit is removed before new arrivals are merged, so a
    // violation landing on its own grant edge starts a fresh report.
    pendBase   = clear ? '0 : (pending_q & ~grantMask);
    ovBase     = clear ? '0 : (overflow_q & ~grantMask);
    overflow_d = ovBase | (acc & pendBase);
    pending_d  = pendBase | acc;

    cntBase     = clear ? '0 : failCount_q;
    sum         = SUM_W'(cntBase) + SUM_W'(accPop);
    failCount_d = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];

    haltReq_d = clear ? 1'b0
              : (haltReq_q || ((HALT_THRESH != 0) && (failCount_q >= HALT_VAL)));
  end

  // State registers. rr pointer resets to the last source so source 0 wins first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      overflow_q   <= '0;
      rrPtr_q      <= ID_W'(N_SRC - 1);
      rptId_q      <= '0;
      rptDropped_q <= 1'b0;
      failCount_q  <= '0;
      haltReq_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      rrPtr_q      <= rrPtr_d;
      rptId_q      <= rptId_d;
      rptDropped_q <= rptDropped_d;
      failCount_q  <= failCount_d;
      haltReq_q    <= haltReq_d;
    end
  end

  assign rpt_valid   = (state_q == REPORT);
  assign rpt_id      = rptId_q;
  assign rpt_dropped = rptDropped_q;
  assign fail_count  = failCount_q;
  assign halt_req    = haltReq_q;

endmodule

// File: tb/tb_assert_report_arbiter.sv
// ---------------------------------------------------------------------------
// tb_assert_report_arbiter
//
// Directed bench for assert_report_arbiter with N_SRC=8, CNT_W=4 and
// HALT_THRESH=1. Each scenario task drives its vectors and compares the
// DUT outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_assert_report_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       clear;
  logic [7:0] fail_i;
  logic       rpt_valid;
  logic       rpt_ready;
  logic [2:0] rpt_id;
  logic       rpt_dropped;
  logic [3:0] fail_count;
  logic       halt_req;

  int compared = 0;
  int mismatched = 0;

  assert_report_arbiter #(
    .N_SRC(8), .ID_W(3), .CNT_W(4), .HALT_THRESH(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
    .fail_i(fail_i), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_id(rpt_id), .rpt_dropped(rpt_dropped), .fail_count(fail_count),
    .halt_req(halt_req)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    enable    = 1'b1;
    clear     = 1'b0;
    fail_i    = 8'h00;
    rpt_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    enable    = 1'b1;
    clear     = 1'b0;
    fail_i    = 8'h00;
    rpt_ready = 1'b0;
    tick();
    compared++; if (rpt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", rpt_valid); end
    compared++; if (rpt_id !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_id: got %0d expected 0", rpt_id); end
    compared++; if (rpt_dropped !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dropped: got %b expected 0", rpt_dropped); end
    compared++; if (fail_count !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", fail_count); end
    compared++; if (halt_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_halt: got %b expected 0", halt_req); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_report();
    apply_reset();
    fail_i = 8'h04;
    tick();
    fail_i = 8'h00;
    compared++; if (rpt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t1_valid_early: got %b expected 0", rpt_valid); end
    compared++; if (fail_count !== 4'd1) begin mismatched++; $display("[TB] FAIL t1_count: got %0d expected 1", fail_count); end
    compared++; if (halt_req !== 1'b0) begin mismatched++; $display("[TB] FAIL t1_halt_early: got %b expected 0", halt_req); end
    tick();
    compared++; if (rpt_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL t1_valid: got %b expected 1", rpt_valid); end
    compared++; if (rpt_id !== 3'd2) begin mismatched++; $display("[TB] FAIL t1_id: got %0d expected 2", rpt_id); end
    compared++; if (rpt_dropped !== 1'b0) begin mismatched++; $display("[TB] FAIL t1_dropped: got %b expected 0", rpt_dropped); end
    compared++; if (halt_req !== 1'b1) begin mismatched++; $display("[TB] FAIL t1_halt: got %b expected 1", halt_req); end
    rpt_ready = 1'b1;
    tick();
    compared++; if (rpt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t1_valid_drop: got %b expected 0", rpt_valid); end
    rpt_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    fail_i    = 8'h81;
    rpt_ready = 1'b1;
    tick();
    fail_i = 8'h00;
    tick();
    compared++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd0) begin mismatched++; $display("[TB] FAIL t2_first: got valid=%b id=%0d expected valid=1 id=0", rpt_valid, rpt_id); end
    tick();
    compared++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd7) begin mismatched++; $display("[TB] FAIL t2_second: got valid=%b id=%0d expected valid=1 id=7", rpt_valid, rpt_id); end
    tick();
    compared++; if (rpt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t2_idle: got %b expected 0", rpt_valid); end
    compared++; if (fail_count !== 4'd2) begin mismatched++; $display("[TB] FAIL t2_count: got %0d expected 2", fail_count); end
    rpt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    apply_reset();
    fail_i = 8'h08;
    tick();
    tick();
    tick();
    fail_i = 8'h00;
    compared++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd3 || rpt_dropped !== 1'b0) begin mismatched++; $display("[TB] FAIL t3_first: got valid=%b id=%0d dropped=%b expected 1/3/0", rpt_valid, rpt_id, rpt_dropped); end
    compared++; if (fail_count !== 4'd3) begin mismatched++; $display("[TB] FAIL t3_count: got %0d expected 3", fail_count); end
    rpt_ready = 1'b1;
    tick();
    compared++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd3 || rpt_dropped !== 1'b1) begin mismatched++; $display("[TB] FAIL t3_merged: got valid=%b id=%0d dropped=%b expected 1/3/1", rpt_valid, rpt_id, rpt_dropped); end
    tick();
    compared++; if (rpt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t3_idle: got %b expected 0", rpt_valid); end
    rpt_ready = 1'b0;
  endtask

  task automatic test_round_robin_saturate();
    apply_reset();
    fail_i = 8'hFF;
    tick();
    fail_i = 8'h00;
    tick();
    rpt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      compared++; if (rpt_valid !== 1'b1 || rpt_id !== 3'(k)) begin mismatched++; $display("[TB] FAIL t4_order: got valid=%b id=%0d expected valid=1 id=%0d", rpt_valid, rpt_id, k); end
      tick();
    end
    compared++; if (rpt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t4_drain: got %b expected 0", rpt_valid); end
    compared++; if (fail_count !== 4'd8) begin mismatched++; $display("[TB] FAIL t4_count8: got %0d expected 8", fail_count); end
    fail_i = 8'h03;
    tick();
    fail_i = 8'h00;
    tick();
    compared++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd0) begin mismatched++; $display("[TB] FAIL t4_wrap0: got valid=%b id=%0d expected valid=1 id=0", rpt_valid, rpt_id); end
    tick();
    compared++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd1) begin mismatched++; $display("[TB] FAIL t4_wrap1: got valid=%b id=%0d expected valid=1 id=1", rpt_valid, rpt_id); end
    tick();
    compared++; if (rpt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t4_wrap_idle: got %b expected 0", rpt_valid); end
    compared++; if (fail_count !== 4'd10) begin mismatched++; $display("[TB] FAIL t4_count10: got %0d expected 10", fail_count); end
    fail_i = 8'hFF;
    tick();
    fail_i = 8'h00;
    compared++; if (fail_count !== 4'd15) begin mismatched++; $display("[TB] FAIL t4_saturate: got %0d expected 15", fail_count); end
    // Last grant was source 1, so the next sweep starts at source 2.
    for (int k = 0; k < 8; k++) begin
      tick();
      compared++; if (rpt_id !== 3'((k + 2) % 8)) begin mismatched++; $display("[TB] FAIL t4_sweep: got id=%0d expected id=%0d", rpt_id, (k + 2) % 8); end
    end
    tick();
    compared++; if (rpt_valid !== 1'b0 || fail_count !== 4'd15) begin mismatched++; $display("[TB] FAIL t4_final: got valid=%b count=%0d expected 0/15", rpt_valid, fail_count); end
    rpt_ready = 1'b0;
  endtask

  task automatic test_clear();
    apply_reset();
    fail_i = 8'h03;
    tick();
    fail_i = 8'h00;
    tick();
    compared++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd0 || halt_req !== 1'b1) begin mismatched++; $display("[TB] FAIL t5_pre: got valid=%b id=%0d halt=%b expected 1/0/1", rpt_valid, rpt_id, halt_req); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    compared++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd0) begin mismatched++; $display("[TB] FAIL t5_held: got valid=%b id=%0d expected 1/0", rpt_valid, rpt_id); end
    compared++; if (fail_count !== 4'd0 || halt_req !== 1'b0) begin mismatched++; $display("[TB] FAIL t5_cleared: got count=%0d halt=%b expected 0/0", fail_count, halt_req); end
    rpt_ready = 1'b1;
    tick();
    compared++; if (rpt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL t5_no_more: got %b expected 0", rpt_valid); end
    tick();
    compared++; if (rpt_valid !== 1'b0 || halt_req !== 1'b0) begin mismatched++; $display("[TB] FAIL t5_quiet: got valid=%b halt=%b expected 0/0", rpt_valid, halt_req); end
    rpt_ready = 1'b0;
  endtask

  task automatic test_enable_and_async_reset();
    apply_reset();
    enable = 1'b0;
    fail_i = 8'hFF;
    tick();
    tick();
    tick();
    compared++; if (rpt_valid !== 1'b0 || fail_count !== 4'd0) begin mismatched++; $display("[TB] FAIL t6_disabled: got valid=%b count=%0d expected 0/0", rpt_valid, fail_count); end
    enable = 1'b1;
    fail_i = 8'h20;
    tick();
    fail_i = 8'h00;
    tick();
    compared++; if (rpt_valid !== 1'b1 || rpt_id !== 3'd5) begin mismatched++; $display("[TB] FAIL t6_report: got valid=%b id=%0d expected 1/5", rpt_valid, rpt_id); end
    #2;
    reset_n = 1'b0;
    #1;
    compared++; if (rpt_valid !== 1'b0 || rpt_id !== 3'd0 || fail_count !== 4'd0) begin mismatched++; $display("[TB] FAIL t6_async_reset: got valid=%b id=%0d count=%0d expected 0/0/0", rpt_valid, rpt_id, fail_count); end
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    clear     = 1'b0;
    fail_i    = 8'h00;
    rpt_ready = 1'b0;
    test_reset();
    test_single_report();
    test_back_to_back();
    test_overflow();
    test_round_robin_saturate();
    test_clear();
    test_enable_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
